// File: rtl/fir_tdm_pkg.sv
// rtl/fir_tdm_pkg.sv - shared types, width helpers and saturation limits for the TDM FIR engine
package fir_tdm_pkg;

  // Engine sequencing: accept a sample, run one MAC per tap, round/saturate, hold the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_RND  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Width of a tap index / buffer pointer
  function automatic int ptr_w(input int ntaps);
    return (ntaps > 1) ? $clog2(ntaps) : 1;
  endfunction

  // Default accumulator width: full product plus growth for summing ntaps products
  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Largest value representable in a signed out_w-bit result
  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed out_w-bit result
  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round half toward +inf, arithmetic shift and clamp of the accumulator
module fir_round_sat
  import fir_tdm_pkg::*;
#(
  parameter int ACC_W = 38,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    ovf_o
);

  // One guard bit so adding the rounding constant can never wrap
  localparam int TW = ACC_W + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [TW-1:0] RND_C = (SHIFT > 0) ? (TW'(1) <<< RS) : '0;
  localparam logic signed [TW-1:0] MAXV  = TW'(sat_max(OUT_W));
  localparam logic signed [TW-1:0] MINV  = TW'(sat_min(OUT_W));

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] sh;

  // Add half an LSB of the output scale, shift down, then clamp into the output range
  always_comb begin
    t      = TW'(acc_i) + RND_C;
    sh     = t >>> SHIFT;
    dout_o = OUT_W'(sh);
    ovf_o  = 1'b0;
    if (sh > MAXV) begin
      dout_o = OUT_W'(MAXV);
      ovf_o  = 1'b1;
    end else if (sh < MINV) begin
      dout_o = OUT_W'(MINV);
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_tdm_engine.sv
// rtl/fir_tdm_engine.sv - time-multiplexed FIR: one MAC per cycle over a circular sample buffer
module fir_tdm_engine
  import fir_tdm_pkg::*;
#(
  parameter int NTAPS  = 64,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = acc_w(DATA_W, COEF_W, NTAPS),
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      coef_we,
  input  logic [ptr_w(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      flush,
  output logic                      busy,
  output logic [OUT_W-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      ovf
);

  localparam int PTR_W = ptr_w(NTAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NTAPS - 1);

  state_t state_q, state_d;

  logic [PTR_W-1:0]         wptr_q;
  logic [PTR_W-1:0]         base_q;
  logic [PTR_W-1:0]         k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] smp_q  [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [OUT_W-1:0]  dout_q;
  logic                     ovf_q;

  logic                     accept;
  logic                     coef_wr;
  logic                     flush_en;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  rs_dout;
  logic                     rs_ovf;

  // Writes and flush only act while idle; either one blocks sample acceptance for that cycle
  assign din_ready  = !rst && !coef_we && !flush && (state_q == ST_IDLE);
  assign accept     = din_valid && din_ready;
  assign coef_wr    = coef_we && (state_q == ST_IDLE);
  assign flush_en   = flush && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dout_valid = (state_q == ST_OUT);
  assign dout       = dout_q;
  assign ovf        = ovf_q;

  // Tap k reads the sample k steps older than the newest one, wrapping around the buffer
  always_comb begin
    if (base_q >= k_q) rd_idx = base_q - k_q;
    else               rd_idx = PTR_W'(int'(base_q) + NTAPS - int'(k_q));
    prod = PW'(smp_q[rd_idx]) * PW'(coef_q[k_q]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_MAC;
      ST_MAC:  if (k_q == LAST)   state_d = ST_RND;
      ST_RND:                     state_d = ST_OUT;
      ST_OUT:  if (dout_ready)    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Pointers, tap counter and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      base_q <= '0;
      k_q    <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      base_q <= wptr_q;
      wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      k_q    <= '0;
      acc_q  <= '0;
    end else if (flush_en) begin
      wptr_q <= '0;
    end else if (state_q == ST_MAC) begin
      acc_q <= acc_q + ACC_W'(prod);
      k_q   <= k_q + 1'b1;
    end
  end

  // Circular sample history: cleared by reset or flush, written on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) smp_q[i] <= '0;
    end else if (flush_en) begin
      for (int i = 0; i < NTAPS; i++) smp_q[i] <= '0;
    end else if (accept) begin
      smp_q[wptr_q] <= din;
    end
  end

  // Coefficient table: writable only while idle, survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i  (acc_q),
    .dout_o (rs_dout),
    .ovf_o  (rs_ovf)
  );

  // Capture the rounded result once; it stays put through any output stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_RND) begin
      dout_q <= rs_dout;
      ovf_q  <= rs_ovf;
    end
  end

endmodule

// File: tb/tb_fir_tdm_engine.sv
// tb/tb_fir_tdm_engine.sv - directed self-checking bench for fir_tdm_engine
module tb_fir_tdm_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               flush;
  logic               dout_ready;

  logic               din_ready0, busy0, dout_valid0, ovf0;
  logic signed [15:0] dout0;
  logic               din_ready1, busy1, dout_valid1, ovf1;
  logic signed [15:0] dout1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_tdm_engine #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush),
    .busy(busy0), .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready), .ovf(ovf0)
  );

  fir_tdm_engine #(.SHIFT(15)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush),
    .busy(busy1), .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready), .ovf(ovf1)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; coef_we = 1'b0; flush = 1'b0; dout_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input longint val);
    coef_we = 1'b1; coef_addr = 6'(addr); coef_data = 16'(val);
    cyc();
    coef_we = 1'b0;
  endtask

  // Feed one sample, optionally poke write+flush mid-MAC, stall the output, check result and latency
  task automatic send(input string tag, input longint x, input int which, input longint exp_y,
                      input longint exp_ov, input int stall, input bit poke);
    int w;
    int lat;
    longint y;
    longint ov;
    w = 0;
    while (!din_ready0 && w < 10) begin cyc(); w++; end
    din = 16'(x); din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    lat = 1;
    while (!dout_valid0 && lat < 200) begin
      if (poke && lat == 10) begin
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'sd100; flush = 1'b1;
      end else begin
        coef_we = 1'b0; flush = 1'b0;
      end
      cyc();
      lat++;
    end
    coef_we = 1'b0; flush = 1'b0;
    chk({tag, "_lat"}, lat, 66);
    y  = (which == 0) ? longint'(dout0) : longint'(dout1);
    ov = (which == 0) ? longint'(ovf0)  : longint'(ovf1);
    chk({tag, "_dout"}, y, exp_y);
    chk({tag, "_ovf"}, ov, exp_ov);
    for (int s = 0; s < stall; s++) begin
      cyc();
      chk({tag, "_bp_valid"}, dout_valid0, 1);
      chk({tag, "_bp_dout"}, dout0, exp_y);
      chk({tag, "_bp_din_ready"}, din_ready0, 0);
    end
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    chk({tag, "_released"}, dout_valid0, 0);
    chk({tag, "_idle_ready"}, din_ready0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; flush = 1'b0; dout_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_din_ready", din_ready0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_dout_valid", dout_valid0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_din_ready", din_ready0, 1);

    // Impulse response with b[k]=k+1, SHIFT=0
    for (int k = 0; k < 64; k++) wr_coef(k, k + 1);
    send("imp0", 1, 0, 1, 0, 0, 1'b0);
    for (int i = 1; i <= 64; i++) send("imp", 0, 0, (i < 64) ? i + 1 : 0, 0, 0, 1'b0);

    // Rounding on the SHIFT=15 instance
    do_reset();
    wr_coef(0, 16384);
    send("rnd_p3", 3, 1, 2, 0, 0, 1'b0);
    send("rnd_m3", -3, 1, -1, 0, 0, 1'b0);

    // Saturation, flush, negative saturation with output backpressure
    do_reset();
    for (int k = 0; k < 64; k++) wr_coef(k, 32767);
    for (int i = 0; i < 64; i++) send("sat_pos", 32767, 0, 32767, 1, 0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_din_ready", din_ready0, 0);
    cyc();
    flush = 1'b0;
    send("sat_neg", -32768, 0, -32768, 1, 20, 1'b0);

    // Gating: write and flush during MAC are ignored
    do_reset();
    wr_coef(0, 1);
    wr_coef(1, 1);
    send("gate_a", 5, 0, 5, 0, 0, 1'b1);
    send("gate_b", 7, 0, 12, 0, 0, 1'b0);
    // Write and sample in the same idle cycle: write wins
    coef_we = 1'b1; coef_addr = 6'd2; coef_data = 16'sd3; din = 16'sd9; din_valid = 1'b1;
    #1;
    chk("same_cycle_din_ready", din_ready0, 0);
    cyc();
    coef_we = 1'b0; din_valid = 1'b0;
    chk("same_cycle_busy", busy0, 0);
    send("gate_c", 2, 0, 24, 0, 0, 1'b0);

    // Reset in the middle of MAC
    for (int k = 0; k < 64; k++) wr_coef(k, k + 1);
    din = 16'sd1; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    repeat (29) cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout0, 0);
    chk("mid_rst_dout_valid", dout_valid0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_din_ready", din_ready0, 0);
    cyc();
    rst = 1'b0;
    send("post_rst_zero_coef", 1, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 64; k++) wr_coef(k, k + 1);
    send("post_rst_imp1", 0, 0, 2, 0, 0, 1'b0);
    send("post_rst_imp2", 0, 0, 3, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
